// File: rtl/dram_l2_resp.sv
// DRAM stand-in for one L2 bank: acks sctag reads/writes, gathers scbuf write beats
// into a small line store and returns read lines as four 128-bit chunks (r0 ctl, r2 data).
module dram_l2_resp #(
  parameter int RD_Q_DEPTH = 4,
  parameter int RD_LAT     = 8,
  parameter int MEM_IDX_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sctag_dram_rd_req,
  input  logic           sctag_dram_rd_dummy_req,
  input  logic [2:0]     sctag_dram_rd_req_id,
  input  logic [34:0]    sctag_dram_addr,
  input  logic           sctag_dram_wr_req,
  input  logic [63:0]    scbuf_dram_wr_data_r5,
  input  logic           scbuf_dram_data_vld_r5,
  input  logic           scbuf_dram_data_mecc_r5,
  output logic           dram_sctag_rd_ack,
  output logic           dram_sctag_wr_ack,
  output logic [1:0]     dram_sctag_chunk_id_r0,
  output logic           dram_sctag_data_vld_r0,
  output logic [2:0]     dram_sctag_rd_req_id_r0,
  output logic [127:0]   dram_scbuf_data_r2,
  output logic [27:0]    dram_scbuf_ecc_r2,
  output logic           dram_sctag_secc_err_r2,
  output logic           dram_sctag_mecc_err_r2,
  output logic           dram_sctag_scb_mecc_err,
  output logic           dram_sctag_scb_secc_err
);

  localparam int QP_W  = (RD_Q_DEPTH > 1) ? $clog2(RD_Q_DEPTH) : 1;
  localparam int QC_W  = QP_W + 1;
  localparam int TS_W  = 8;
  localparam int LINES = 1 << MEM_IDX_W;

  typedef enum logic [0:0] {
    W_IDLE    = 1'b0,
    W_COLLECT = 1'b1
  } wr_state_e;

  // Line store and per-line poison
  logic [511:0]           mem_q [LINES];
  logic [LINES-1:0]       poison_q;

  // Read queue
  logic [2:0]             q_id_q  [RD_Q_DEPTH];
  logic [MEM_IDX_W-1:0]   q_idx_q [RD_Q_DEPTH];
  logic [TS_W-1:0]        q_ts_q  [RD_Q_DEPTH];
  logic [QP_W-1:0]        q_wp_q, q_rp_q;
  logic [QC_W-1:0]        q_cnt_q, q_cnt_d;
  logic [TS_W-1:0]        ts_q;
  logic                   rd_ack_q;

  // Return pipeline r0 -> r1 -> r2
  logic                   r0_vld_q;
  logic [1:0]             r0_chunk_q;
  logic [2:0]             r0_id_q;
  logic [MEM_IDX_W-1:0]   r0_idx_q;
  logic                   r1_vld_q;
  logic [1:0]             r1_chunk_q;
  logic [511:0]           line_q;
  logic                   line_poison_q;
  logic [127:0]           r2_data_q;
  logic                   r2_mecc_q;

  // Write collector
  wr_state_e              wr_state_q;
  logic                   wr_ack_q;
  logic [MEM_IDX_W-1:0]   wr_idx_q;
  logic [2:0]             beat_cnt_q;
  logic                   wpois_q;
  logic                   scb_mecc_q;
  logic [63:0]            wbuf_q [8];

  logic                   q_full_s;
  logic                   rd_take_s;
  logic                   push_s;
  logic                   pop_s;
  logic [TS_W-1:0]        head_age_s;
  logic                   head_rdy_s;
  logic                   busy_s;
  logic                   start_s;
  logic                   beat_s;
  logic                   commit_s;
  logic                   unused_addr_s;

  assign unused_addr_s = ^sctag_dram_addr[34:MEM_IDX_W];

  // Read-side decisions: accept, queue push/pop and return-engine start
  always_comb begin
    q_full_s   = (q_cnt_q == QC_W'(RD_Q_DEPTH));
    rd_take_s  = sctag_dram_rd_req && !rd_ack_q && (sctag_dram_rd_dummy_req || !q_full_s);
    push_s     = rd_take_s && !sctag_dram_rd_dummy_req;
    pop_s      = r0_vld_q && (r0_chunk_q == 2'd2);
    head_age_s = ts_q - q_ts_q[q_rp_q];
    head_rdy_s = (q_cnt_q != QC_W'(0)) && (head_age_s >= TS_W'(RD_LAT - 1));
    busy_s     = r0_vld_q && (r0_chunk_q != 2'd3);
    start_s    = !busy_s && head_rdy_s;
    case ({push_s, pop_s})
      2'b10:   q_cnt_d = q_cnt_q + QC_W'(1);
      2'b01:   q_cnt_d = q_cnt_q - QC_W'(1);
      default: q_cnt_d = q_cnt_q;
    endcase
  end

  // Write-side beat qualification
  always_comb begin
    beat_s   = (wr_state_q == W_COLLECT) && scbuf_dram_data_vld_r5;
    commit_s = beat_s && (beat_cnt_q == 3'd7);
  end

  // Read accept, queue pointers and the r0/r1/r2 return pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      rd_ack_q   <= 1'b0;
      q_wp_q     <= '0;
      q_rp_q     <= '0;
      q_cnt_q    <= '0;
      r0_vld_q   <= 1'b0;
      r0_chunk_q <= 2'd0;
      r0_id_q    <= 3'd0;
      r0_idx_q   <= '0;
      r1_vld_q   <= 1'b0;
      r1_chunk_q <= 2'd0;
      r2_data_q  <= '0;
      r2_mecc_q  <= 1'b0;
    end else begin
      ts_q     <= ts_q + TS_W'(1);
      rd_ack_q <= rd_take_s;
      q_cnt_q  <= q_cnt_d;
      if (push_s) begin
        q_wp_q <= q_wp_q + QP_W'(1);
      end
      if (pop_s) begin
        q_rp_q <= q_rp_q + QP_W'(1);
      end
      if (start_s) begin
        r0_vld_q   <= 1'b1;
        r0_chunk_q <= 2'd0;
        r0_id_q    <= q_id_q[q_rp_q];
        r0_idx_q   <= q_idx_q[q_rp_q];
      end else if (busy_s) begin
        r0_chunk_q <= r0_chunk_q + 2'd1;
      end else begin
        r0_vld_q   <= 1'b0;
        r0_chunk_q <= 2'd0;
        r0_id_q    <= 3'd0;
      end
      r1_vld_q   <= r0_vld_q;
      r1_chunk_q <= r0_chunk_q;
      r2_data_q  <= r1_vld_q ? line_q[{r1_chunk_q, 7'd0} +: 128] : 128'd0;
      r2_mecc_q  <= r1_vld_q && line_poison_q;
    end
  end

  // Queue payload and line snapshot; the line is sampled during the chunk-0 r0 cycle
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_id_q[q_wp_q]  <= sctag_dram_rd_req_id;
      q_idx_q[q_wp_q] <= sctag_dram_addr[MEM_IDX_W-1:0];
      q_ts_q[q_wp_q]  <= ts_q + TS_W'(1);
    end
    if (r0_vld_q && (r0_chunk_q == 2'd0)) begin
      line_q        <= mem_q[r0_idx_q];
      line_poison_q <= poison_q[r0_idx_q];
    end
  end

  // Write collector FSM: ack, count 8 beats, commit poison on beat 7
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wr_ack_q   <= 1'b0;
      wr_idx_q   <= '0;
      beat_cnt_q <= 3'd0;
      wpois_q    <= 1'b0;
      scb_mecc_q <= 1'b0;
      poison_q   <= '0;
    end else begin
      wr_ack_q   <= 1'b0;
      scb_mecc_q <= 1'b0;
      case (wr_state_q)
        W_IDLE: begin
          if (sctag_dram_wr_req) begin
            wr_ack_q   <= 1'b1;
            wr_idx_q   <= sctag_dram_addr[MEM_IDX_W-1:0];
            beat_cnt_q <= 3'd0;
            wpois_q    <= 1'b0;
            wr_state_q <= W_COLLECT;
          end
        end
        W_COLLECT: begin
          if (commit_s) begin
            poison_q[wr_idx_q] <= wpois_q | scbuf_dram_data_mecc_r5;
            scb_mecc_q         <= wpois_q | scbuf_dram_data_mecc_r5;
            beat_cnt_q         <= 3'd0;
            wpois_q            <= 1'b0;
            wr_state_q         <= W_IDLE;
          end else if (beat_s) begin
            beat_cnt_q <= beat_cnt_q + 3'd1;
            wpois_q    <= wpois_q | scbuf_dram_data_mecc_r5;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Beat buffer and line-store commit (line data is deliberately not reset)
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_q[wr_idx_q] <= {scbuf_dram_wr_data_r5, wbuf_q[6], wbuf_q[5], wbuf_q[4],
                          wbuf_q[3], wbuf_q[2], wbuf_q[1], wbuf_q[0]};
    end else if (beat_s) begin
      wbuf_q[beat_cnt_q] <= scbuf_dram_wr_data_r5;
    end
  end

  assign dram_sctag_rd_ack       = rd_ack_q;
  assign dram_sctag_wr_ack       = wr_ack_q;
  assign dram_sctag_data_vld_r0  = r0_vld_q;
  assign dram_sctag_chunk_id_r0  = r0_chunk_q;
  assign dram_sctag_rd_req_id_r0 = r0_id_q;
  assign dram_scbuf_data_r2      = r2_data_q;
  assign dram_sctag_mecc_err_r2  = r2_mecc_q;
  assign dram_sctag_scb_mecc_err = scb_mecc_q;
  // The store holds no real ECC; correctable-error paths are tied off
  assign dram_scbuf_ecc_r2       = 28'd0;
  assign dram_sctag_secc_err_r2  = 1'b0;
  assign dram_sctag_scb_secc_err = 1'b0;

endmodule
